// File: rtl/int_res_mem_arbiter_if.sv
// Requester/memory bundle for the intermediate-result memory arbiter.
// slave = arbiter side, master = requesters plus memory.
interface int_res_mem_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 24
);
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0]             req_write;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
    logic                           prio0_en;
    logic [NUM_REQ-1:0]             gnt;
    logic                           mem_chip_en;
    logic                           mem_write_en;
    logic [ADDR_W-1:0]              mem_addr;
    logic [DATA_W-1:0]              mem_wdata;
    logic [DATA_W-1:0]              mem_rdata;
    logic [NUM_REQ-1:0]             rd_valid;
    logic [DATA_W-1:0]              rd_data;
    logic                           busy;

    modport slave (
        input  req, req_write, req_addr, req_wdata, prio0_en, mem_rdata,
        output gnt, mem_chip_en, mem_write_en, mem_addr, mem_wdata,
               rd_valid, rd_data, busy
    );

    modport master (
        output req, req_write, req_addr, req_wdata, prio0_en, mem_rdata,
        input  gnt, mem_chip_en, mem_write_en, mem_addr, mem_wdata,
               rd_valid, rd_data, busy
    );
endinterface

// File: rtl/int_res_mem_arbiter.sv
// Single-port memory arbiter: optional strict priority for requester 0, else
// round-robin; registered memory command and in-order read-return tracking.
module int_res_mem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 24,
    parameter int RD_LAT  = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    int_res_mem_arbiter_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ID_W-1:0]              rr_ptr;
    logic [ID_W-1:0]              gnt_id;
    logic                         gnt_any;
    logic                         chip_en_q;
    logic                         write_en_q;
    logic [ADDR_W-1:0]            addr_q;
    logic [DATA_W-1:0]            wdata_q;
    // stage k is valid in cycle grant+1+k; stage RD_LAT lines up with mem_rdata
    logic [RD_LAT:0]              vld_pipe;
    logic [RD_LAT:0][ID_W-1:0]    id_pipe;

    always_comb begin
        logic [ID_W:0] sum;
        gnt_any = 1'b0;
        gnt_id  = '0;
        sum     = '0;
        if (bus.prio0_en && bus.req[0]) begin
            gnt_any = 1'b1;
        end else begin
            // scan downward so the nearest index at/after rr_ptr wins
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
                if (sum >= (ID_W+1)'(NUM_REQ))
                    sum = sum - (ID_W+1)'(NUM_REQ);
                if (bus.req[sum[ID_W-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_id  = sum[ID_W-1:0];
                end
            end
        end
        if (!rst_n)
            gnt_any = 1'b0;
    end

    assign bus.gnt = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            chip_en_q  <= 1'b0;
            write_en_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            vld_pipe   <= '0;
            id_pipe    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_LAT-1:0], gnt_any & ~bus.req_write[gnt_id]};
            id_pipe  <= {id_pipe[RD_LAT-1:0], gnt_id};
            if (gnt_any) begin
                chip_en_q  <= 1'b1;
                write_en_q <= bus.req_write[gnt_id];
                addr_q     <= bus.req_addr[gnt_id];
                wdata_q    <= bus.req_wdata[gnt_id];
                rr_ptr     <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            end else begin
                chip_en_q  <= 1'b0;
                write_en_q <= 1'b0;
            end
        end
    end

    assign bus.mem_chip_en  = chip_en_q;
    assign bus.mem_write_en = write_en_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.rd_valid     = vld_pipe[RD_LAT] ? (NUM_REQ'(1) << id_pipe[RD_LAT]) : '0;
    assign bus.rd_data      = bus.mem_rdata;
    assign bus.busy         = chip_en_q | (|vld_pipe);
endmodule

// File: tb/tb_int_res_mem_arbiter.sv
// Bench for int_res_mem_arbiter: directed scenarios plus random traffic,
// checked every cycle against a cycle-indexed expectation model.
module tb_int_res_mem_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 24;
    localparam int RD_LAT  = 2;
    localparam int DEPTH   = 256;
    localparam int MAXC    = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int_res_mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    int_res_mem_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // memory with RD_LAT cycles from command to data
    logic [DATA_W-1:0] mem   [DEPTH];
    logic [DATA_W-1:0] rpipe [RD_LAT+1];
    always @(posedge clk) begin
        if (bus.mem_chip_en && bus.mem_write_en)
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        rpipe[1] <= (bus.mem_chip_en && !bus.mem_write_en) ? mem[bus.mem_addr[7:0]] : '0;
        for (int k = 2; k <= RD_LAT; k++)
            rpipe[k] <= rpipe[k-1];
    end
    assign bus.mem_rdata = rpipe[RD_LAT];

    // reference model state
    int                errors = 0;
    int                checks = 0;
    int                cyc    = 0;
    int                m_rr;
    bit                m_chip, m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    int                exp_rdv   [MAXC];
    logic [DATA_W-1:0] exp_rdata [MAXC];
    bit                exp_fly   [MAXC];
    logic [DATA_W-1:0] ref_mem   [DEPTH];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        m_rr = 0; m_chip = 0; m_we = 0; m_addr = '0; m_wdata = '0;
        for (int c = 0; c < MAXC; c++) begin
            exp_rdv[c] = -1; exp_rdata[c] = '0; exp_fly[c] = 0;
        end
    endtask

    // compare this cycle's outputs, then advance the model by this cycle's inputs
    task automatic model_cycle();
        int g;
        int idx;
        g = -1;
        if (bus.prio0_en && bus.req[0]) g = 0;
        else
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (m_rr + k) % NUM_REQ;
                if (g < 0 && bus.req[idx]) g = idx;
            end
        chk("gnt", 64'(bus.gnt), (g < 0) ? 64'd0 : 64'd1 << g);
        chk("chip_en", 64'(bus.mem_chip_en), 64'(m_chip));
        chk("write_en", 64'(bus.mem_write_en), 64'(m_we));
        chk("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
        chk("mem_wdata", 64'(bus.mem_wdata), 64'(m_wdata));
        chk("rd_valid", 64'(bus.rd_valid), (exp_rdv[cyc] < 0) ? 64'd0 : 64'd1 << exp_rdv[cyc]);
        if (exp_rdv[cyc] >= 0)
            chk("rd_data", 64'(bus.rd_data), 64'(exp_rdata[cyc]));
        chk("busy", 64'(bus.busy), 64'(m_chip | exp_fly[cyc]));
        if (g >= 0) begin
            m_chip  = 1;
            m_we    = bus.req_write[g];
            m_addr  = bus.req_addr[g];
            m_wdata = bus.req_wdata[g];
            if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
            else begin
                exp_rdv[cyc+1+RD_LAT]   = g;
                exp_rdata[cyc+1+RD_LAT] = ref_mem[m_addr[7:0]];
                for (int c = cyc + 1; c <= cyc + 1 + RD_LAT; c++) exp_fly[c] = 1;
            end
            m_rr = (g + 1) % NUM_REQ;
        end else begin
            m_chip = 0;
            m_we   = 0;
        end
    endtask

    // inputs are driven at posedge+1; outputs are checked at the negedge
    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        bus.req = '0;
        bus.prio0_en = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_req(input int i, input bit w, input int a, input int d);
        bus.req[i]       = 1'b1;
        bus.req_write[i] = w;
        bus.req_addr[i]  = ADDR_W'(a);
        bus.req_wdata[i] = DATA_W'(d);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req = '0;
        bus.prio0_en = 1'b0;
        #1;
        chk("rst_gnt", 64'(bus.gnt), 0);
        chk("rst_chip_en", 64'(bus.mem_chip_en), 0);
        chk("rst_write_en", 64'(bus.mem_write_en), 0);
        chk("rst_addr", 64'(bus.mem_addr), 0);
        chk("rst_wdata", 64'(bus.mem_wdata), 0);
        chk("rst_rd_valid", 64'(bus.rd_valid), 0);
        chk("rst_busy", 64'(bus.busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
        model_clear();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = DATA_W'(i * 3 + 7);
            ref_mem[i] = DATA_W'(i * 3 + 7);
        end
        for (int k = 0; k <= RD_LAT; k++) rpipe[k] = '0;
        bus.req = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.prio0_en = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // all four reading, plain round-robin
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 0, 16 + i, 0);
        for (int n = 0; n < 5; n++) step();
        idle(5);

        // strict priority for requester 0, then back to round-robin
        bus.req = '1;
        bus.prio0_en = 1'b1;
        for (int n = 0; n < 4; n++) step();
        bus.prio0_en = 1'b0;
        step();
        idle(5);

        // write then read-back of the same address by requester 2
        set_req(2, 1, 'h10, 'h00ABCD);
        step();
        set_req(2, 0, 'h10, 0);
        step();
        idle(5);

        // lone requester 3 held for 5 cycles, then all request to expose rr_ptr
        for (int n = 0; n < 5; n++) begin
            set_req(3, 0, 'h20 + n, 0);
            step();
        end
        bus.req = '1;
        step();
        idle(5);

        // two reads in flight when reset pulses
        set_req(0, 0, 1, 0);
        step();
        bus.req = '0;
        set_req(1, 0, 2, 0);
        step();
        do_reset();
        idle(5);

        // traffic, then quiet while the pipeline drains
        set_req(1, 1, 'h33, 'h123456);
        set_req(3, 0, 'h33, 0);
        step();
        step();
        idle(6);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                bus.req[i]       = ($urandom_range(0, 99) < 60);
                bus.req_write[i] = $urandom_range(0, 1) == 1;
                bus.req_addr[i]  = ADDR_W'($urandom_range(0, 15));
                bus.req_wdata[i] = DATA_W'($urandom);
            end
            bus.prio0_en = ($urandom_range(0, 3) == 0);
            step();
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
